machine_cycle_gen: RTL and testbench

//  Internal machine-cycle timing generator; replaces the pad-driven clk1/clk2 front end of timing_io.

---
 rtl/machine_cycle_pkg.sv | 39 +++
 rtl/mcg_phase_div.sv | 90 +++++++++
 rtl/machine_cycle_gen.sv | 207 ++++++++++++++++++++
 tb/tb_machine_cycle_gen.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/machine_cycle_pkg.sv
// Shared types and constants for the machine-cycle timing generator.
package machine_cycle_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_STEP  = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        PH_P0 = 2'd0,
        PH_P1 = 2'd1,
        PH_P2 = 2'd2,
        PH_P3 = 2'd3
    } phase_e;

    localparam int SLOT_A1 = 0;
    localparam int SLOT_A2 = 1;
    localparam int SLOT_A3 = 2;
    localparam int SLOT_M1 = 3;
    localparam int SLOT_M2 = 4;
    localparam int SLOT_X1 = 5;
    localparam int SLOT_X2 = 6;
    localparam int SLOT_X3 = 7;

    localparam int DEFAULT_SLOTS = 8;

    function automatic phase_e next_phase(input phase_e p);
        case (p)
            PH_P0:   return PH_P1;
            PH_P1:   return PH_P2;
            PH_P2:   return PH_P3;
            PH_P3:   return PH_P0;
            default: return PH_P0;
        endcase
    endfunction

endpackage

// File: rtl/mcg_phase_div.sv
// Phase-length timer: loadable down-counter ticking on the last sysclk of a phase.
// With MACHINE_CYCLE_EXT_CLK_EN defined, phase ends come from synchronised pad edges instead.
module mcg_phase_div
    import machine_cycle_pkg::*;
#(
    parameter int DIV_W = 8
) (
    input  logic             sysclk,
    input  logic             poc,
`ifdef MACHINE_CYCLE_EXT_CLK_EN
    input  logic             clk1_pad,
    input  logic             clk2_pad,
    input  phase_e           phase,
    output logic             rise1,
`else
    input  logic             load,
    input  logic [DIV_W-1:0] load_val,
    output logic             tick_nxt,
`endif
    output logic             tick
);

`ifdef MACHINE_CYCLE_EXT_CLK_EN
    // [0],[1] are the synchroniser stages, [2] is the previous synchronised value
    logic [2:0] c1_q, c1_d;
    logic [2:0] c2_q, c2_d;
    logic       fall1_s, rise2_s, fall2_s;

    // shift pad samples through synchroniser and edge-detect history
    always_comb begin
        c1_d = {c1_q[1:0], clk1_pad};
        c2_d = {c2_q[1:0], clk2_pad};
    end

    // synchroniser registers
    always_ff @(posedge sysclk) begin
        if (poc) begin
            c1_q <= 3'b000;
            c2_q <= 3'b000;
        end else begin
            c1_q <= c1_d;
            c2_q <= c2_d;
        end
    end

    assign rise1   =  c1_q[1] & ~c1_q[2];
    assign fall1_s = ~c1_q[1] &  c1_q[2];
    assign rise2_s =  c2_q[1] & ~c2_q[2];
    assign fall2_s = ~c2_q[1] &  c2_q[2];

    // each phase ends on the pad edge that opens the following phase
    always_comb begin
        tick = 1'b0;
        case (phase)
            PH_P0:   tick = fall1_s;
            PH_P1:   tick = rise2_s;
            PH_P2:   tick = fall2_s;
            PH_P3:   tick = rise1;
            default: tick = 1'b0;
        endcase
    end
`else
    logic [DIV_W-1:0] cnt_q, cnt_d;

    // reload at phase start, otherwise count down and hold at zero
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != {DIV_W{1'b0}}) begin
            cnt_d = cnt_q - {{(DIV_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // counter register
    always_ff @(posedge sysclk) begin
        if (poc) begin
            cnt_q <= {DIV_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick     = (cnt_q == {DIV_W{1'b0}});
    assign tick_nxt = (cnt_d == {DIV_W{1'b0}});
`endif

endmodule

// File: rtl/machine_cycle_gen.sv
// Machine-cycle timing generator: two-phase clk1/clk2, one-hot slot strobes, sync and cycle counter.
// Define MACHINE_CYCLE_EXT_CLK_EN to time phases from clk1_pad/clk2_pad instead of the divider.
module machine_cycle_gen
    import machine_cycle_pkg::*;
#(
    parameter int DIV_W = 8,
    parameter int SLOTS = DEFAULT_SLOTS,
    parameter int CNT_W = 16
) (
    input  logic             sysclk,
    input  logic             poc,
    input  logic [DIV_W-1:0] div,
    input  logic             run,
    input  logic             step_req,
`ifdef MACHINE_CYCLE_EXT_CLK_EN
    input  logic             clk1_pad,
    input  logic             clk2_pad,
`endif
    output logic             busy,
    output logic             clk1,
    output logic             clk2,
    output logic [SLOTS-1:0] slot,
    output logic             sync,
    output logic             cycle_done,
    output logic [CNT_W-1:0] cycle_cnt
);

    localparam int SLOT_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SLOTS - 1);

    state_e           state_q, state_d;
    phase_e           phase_q, phase_d;
    logic [SLOT_W-1:0] slot_idx_q, slot_idx_d;
    logic [DIV_W-1:0] div_l_q, div_l_d;

    logic             busy_q, busy_d;
    logic             clk1_q, clk1_d;
    logic             clk2_q, clk2_d;
    logic [SLOTS-1:0] slot_q, slot_d;
    logic             sync_q, sync_d;
    logic             cycle_done_q, cycle_done_d;
    logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;

    logic             tick_s;
    logic             tick_nxt_s;
    logic             load_s;
    logic             go_s;
    logic             eoc_s;

`ifdef MACHINE_CYCLE_EXT_CLK_EN
    logic             rise1_s;
    logic             step_pend_q, step_pend_d;

    mcg_phase_div #(.DIV_W(DIV_W)) u_phase_div (
        .sysclk   (sysclk),
        .poc      (poc),
        .clk1_pad (clk1_pad),
        .clk2_pad (clk2_pad),
        .phase    (phase_q),
        .rise1    (rise1_s),
        .tick     (tick_s)
    );

    assign tick_nxt_s = 1'b0;

    // a step request made in IDLE is held until the pad cycle starts
    always_comb begin
        go_s = (run | step_req | step_pend_q) & rise1_s;
        if (state_q == ST_IDLE) begin
            step_pend_d = (step_req | step_pend_q) & ~go_s;
        end else begin
            step_pend_d = 1'b0;
        end
    end

    // pending-step register
    always_ff @(posedge sysclk) begin
        if (poc) begin
            step_pend_q <= 1'b0;
        end else begin
            step_pend_q <= step_pend_d;
        end
    end
`else
    mcg_phase_div #(.DIV_W(DIV_W)) u_phase_div (
        .sysclk   (sysclk),
        .poc      (poc),
        .load     (load_s),
        .load_val (div_l_d),
        .tick_nxt (tick_nxt_s),
        .tick     (tick_s)
    );

    assign go_s = run | step_req;
`endif

    // sequencer next state, phase/slot advance and divider reload
    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        slot_idx_d = slot_idx_q;
        div_l_d    = div_l_q;
        load_s     = 1'b0;
        eoc_s      = (state_q != ST_IDLE) && (phase_q == PH_P3) &&
                     (slot_idx_q == SLOT_LAST) && tick_s;
        case (state_q)
            ST_IDLE: begin
                phase_d    = PH_P0;
                slot_idx_d = {SLOT_W{1'b0}};
                if (go_s) begin
                    state_d = run ? ST_RUN : ST_STEP;
                    div_l_d = div;
                    load_s  = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN, ST_DRAIN, ST_STEP: begin
                if (run) begin
                    state_d = ST_RUN;
                end else if (eoc_s) begin
                    state_d = ST_IDLE;
                end else if (state_q == ST_RUN) begin
                    state_d = ST_DRAIN;
                end else begin
                    state_d = state_q;
                end
                if (tick_s) begin
                    load_s  = 1'b1;
                    phase_d = next_phase(phase_q);
                    if (phase_q != PH_P3) begin
                        slot_idx_d = slot_idx_q;
                    end else if (slot_idx_q == SLOT_LAST) begin
                        slot_idx_d = {SLOT_W{1'b0}};
                        div_l_d    = div;
                    end else begin
                        slot_idx_d = slot_idx_q + {{(SLOT_W-1){1'b0}}, 1'b1};
                    end
                end else begin
                    load_s = 1'b0;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                phase_d    = PH_P0;
                slot_idx_d = {SLOT_W{1'b0}};
            end
        endcase
    end

    // outputs decoded from the next position so they are registered yet aligned with it
    always_comb begin
        busy_d = (state_d != ST_IDLE);
        clk1_d = busy_d && (phase_d == PH_P0);
        clk2_d = busy_d && (phase_d == PH_P2);
        slot_d = {{(SLOTS-1){1'b0}}, 1'b1} << slot_idx_d;
        sync_d = busy_d && (slot_idx_d == SLOT_LAST);
`ifdef MACHINE_CYCLE_EXT_CLK_EN
        cycle_done_d = eoc_s;
`else
        cycle_done_d = busy_d && (phase_d == PH_P3) && (slot_idx_d == SLOT_LAST) && tick_nxt_s;
`endif
        if (cycle_done_d) begin
            cycle_cnt_d = cycle_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cycle_cnt_d = cycle_cnt_q;
        end
    end

    // state and output registers
    always_ff @(posedge sysclk) begin
        if (poc) begin
            state_q      <= ST_IDLE;
            phase_q      <= PH_P0;
            slot_idx_q   <= {SLOT_W{1'b0}};
            div_l_q      <= {DIV_W{1'b0}};
            busy_q       <= 1'b0;
            clk1_q       <= 1'b0;
            clk2_q       <= 1'b0;
            slot_q       <= {{(SLOTS-1){1'b0}}, 1'b1};
            sync_q       <= 1'b0;
            cycle_done_q <= 1'b0;
            cycle_cnt_q  <= {CNT_W{1'b0}};
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            slot_idx_q   <= slot_idx_d;
            div_l_q      <= div_l_d;
            busy_q       <= busy_d;
            clk1_q       <= clk1_d;
            clk2_q       <= clk2_d;
            slot_q       <= slot_d;
            sync_q       <= sync_d;
            cycle_done_q <= cycle_done_d;
            cycle_cnt_q  <= cycle_cnt_d;
        end
    end

    assign busy       = busy_q;
    assign clk1       = clk1_q;
    assign clk2       = clk2_q;
    assign slot       = slot_q;
    assign sync       = sync_q;
    assign cycle_done = cycle_done_q;
    assign cycle_cnt  = cycle_cnt_q;

endmodule

// File: tb/tb_machine_cycle_gen.sv
// Directed self-checking bench for machine_cycle_gen (internal divider build, CNT_W=4).
module tb_machine_cycle_gen;

    logic       clk;
    logic       poc;
    logic [7:0] div;
    logic       run;
    logic       step_req;
    logic       busy, clk1, clk2, sync, cycle_done;
    logic [7:0] slot;
    logic [3:0] cycle_cnt;

    int         checks;
    int         errors;
    logic [3:0] exp_cnt;

    machine_cycle_gen #(.DIV_W(8), .SLOTS(8), .CNT_W(4)) dut (
        .sysclk     (clk),
        .poc        (poc),
        .div        (div),
        .run        (run),
        .step_req   (step_req),
        .busy       (busy),
        .clk1       (clk1),
        .clk2       (clk2),
        .slot       (slot),
        .sync       (sync),
        .cycle_done (cycle_done),
        .cycle_cnt  (cycle_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        poc = 1'b1; run = 1'b0; step_req = 1'b0; div = 8'd0;
        repeat (2) @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if ({busy, clk1, clk2, sync, cycle_done} !== 5'b00000) begin
                errors++; $display("FAIL reset_flags i=%0d got %b exp 00000", i, {busy, clk1, clk2, sync, cycle_done});
            end
            checks++;
            if (slot !== 8'h01) begin
                errors++; $display("FAIL reset_slot i=%0d got %h exp 01", i, slot);
            end
            checks++;
            if (cycle_cnt !== 4'd0) begin
                errors++; $display("FAIL reset_cnt i=%0d got %0d exp 0", i, cycle_cnt);
            end
            poc = 1'b0;
        end
        exp_cnt = 4'd0;
    endtask

    // div=0 single step; a second step_req while busy must be ignored
    task automatic test_step();
        logic       e_c1, e_c2, e_sy, e_dn, e_bz;
        logic [7:0] e_sl;
        logic [3:0] e_cn;
        div = 8'd0; step_req = 1'b1;
        @(posedge clk);
        for (int k = 0; k <= 33; k++) begin
            @(negedge clk);
            e_bz = (k < 32);
            e_c1 = e_bz && (k % 4 == 0);
            e_c2 = e_bz && (k % 4 == 2);
            e_sy = (k >= 28) && (k < 32);
            e_dn = (k == 31);
            e_sl = e_bz ? (8'd1 << (k / 4)) : 8'd1;
            e_cn = (k >= 31) ? exp_cnt + 4'd1 : exp_cnt;
            checks++;
            if ({busy, clk1, clk2, sync, cycle_done} !== {e_bz, e_c1, e_c2, e_sy, e_dn}) begin
                errors++; $display("FAIL step_flags k=%0d got %b exp %b", k, {busy, clk1, clk2, sync, cycle_done}, {e_bz, e_c1, e_c2, e_sy, e_dn});
            end
            checks++;
            if (slot !== e_sl) begin
                errors++; $display("FAIL step_slot k=%0d got %h exp %h", k, slot, e_sl);
            end
            checks++;
            if (cycle_cnt !== e_cn) begin
                errors++; $display("FAIL step_cnt k=%0d got %0d exp %0d", k, cycle_cnt, e_cn);
            end
            step_req = (k == 10);
        end
        exp_cnt = exp_cnt + 4'd1;
    endtask

    // div=2, run across two cycles then dropped in the second: 96 sysclk per cycle
    task automatic test_run_div2();
        logic       e_c1, e_c2, e_dn, e_bz;
        logic [7:0] e_sl;
        logic [3:0] e_cn;
        div = 8'd2; run = 1'b1;
        @(posedge clk);
        for (int k = 0; k <= 193; k++) begin
            @(negedge clk);
            e_bz = (k < 192);
            e_c1 = e_bz && ((k % 12) < 3);
            e_c2 = e_bz && ((k % 12) >= 6) && ((k % 12) < 9);
            e_dn = (k == 95) || (k == 191);
            e_sl = e_bz ? (8'd1 << ((k / 12) % 8)) : 8'd1;
            e_cn = exp_cnt + ((k >= 95) ? 4'd1 : 4'd0) + ((k >= 191) ? 4'd1 : 4'd0);
            checks++;
            if ({busy, clk1, clk2, cycle_done} !== {e_bz, e_c1, e_c2, e_dn}) begin
                errors++; $display("FAIL div2_flags k=%0d got %b exp %b", k, {busy, clk1, clk2, cycle_done}, {e_bz, e_c1, e_c2, e_dn});
            end
            checks++;
            if (slot !== e_sl) begin
                errors++; $display("FAIL div2_slot k=%0d got %h exp %h", k, slot, e_sl);
            end
            checks++;
            if (cycle_cnt !== e_cn) begin
                errors++; $display("FAIL div2_cnt k=%0d got %0d exp %0d", k, cycle_cnt, e_cn);
            end
            run = (k < 100);
        end
        exp_cnt = exp_cnt + 4'd2;
    endtask

    // run dropped in M1 then re-raised during DRAIN; later dropped for a clean drain
    task automatic test_drain();
        logic e_c1, e_sy, e_dn, e_bz;
        div = 8'd0; run = 1'b1;
        @(posedge clk);
        for (int k = 0; k <= 65; k++) begin
            @(negedge clk);
            e_bz = (k < 64);
            e_c1 = e_bz && (k % 4 == 0);
            e_sy = e_bz && ((k % 32) >= 28);
            e_dn = (k == 31) || (k == 63);
            checks++;
            if ({busy, clk1, sync, cycle_done} !== {e_bz, e_c1, e_sy, e_dn}) begin
                errors++; $display("FAIL drain_flags k=%0d got %b exp %b", k, {busy, clk1, sync, cycle_done}, {e_bz, e_c1, e_sy, e_dn});
            end
            run = !((k >= 13) && (k < 20)) && (k < 40);
        end
        exp_cnt = exp_cnt + 4'd2;
        checks++;
        if (cycle_cnt !== exp_cnt) begin
            errors++; $display("FAIL drain_cnt got %0d exp %0d", cycle_cnt, exp_cnt);
        end
    endtask

    // div changes 0->5 mid-cycle: current cycle keeps 32 sysclk, the next takes 192
    task automatic test_div_change();
        logic e_c1, e_dn, e_bz;
        div = 8'd0; run = 1'b1;
        @(posedge clk);
        for (int k = 0; k <= 225; k++) begin
            @(negedge clk);
            e_bz = (k < 224);
            if (k < 32) e_c1 = (k % 4 == 0);
            else        e_c1 = e_bz && (((k - 32) % 24) < 6);
            e_dn = (k == 31) || (k == 223);
            checks++;
            if ({busy, clk1, cycle_done} !== {e_bz, e_c1, e_dn}) begin
                errors++; $display("FAIL divchg_flags k=%0d got %b exp %b", k, {busy, clk1, cycle_done}, {e_bz, e_c1, e_dn});
            end
            div = (k >= 10) ? 8'd5 : 8'd0;
            run = (k < 40);
        end
        div = 8'd0;
        exp_cnt = exp_cnt + 4'd2;
    endtask

    // poc in slot X1 / P2 returns everything to reset values on the next edge
    task automatic test_poc();
        div = 8'd0; run = 1'b1;
        @(posedge clk);
        for (int k = 0; k <= 25; k++) begin
            @(negedge clk);
            if (k == 21) begin
                checks++;
                if (cycle_cnt !== exp_cnt) begin
                    errors++; $display("FAIL poc_precnt got %0d exp %0d", cycle_cnt, exp_cnt);
                end
            end
            if (k == 22) begin
                checks++;
                if ({clk1, clk2, slot} !== {1'b0, 1'b1, 8'h20}) begin
                    errors++; $display("FAIL poc_x1p2 got %b/%h exp 01/20", {clk1, clk2}, slot);
                end
                poc = 1'b1; run = 1'b0;
            end
            if (k >= 23) begin
                checks++;
                if ({busy, clk1, clk2, sync, cycle_done, slot, cycle_cnt} !== {5'b00000, 8'h01, 4'd0}) begin
                    errors++; $display("FAIL poc_reset k=%0d got %b/%h/%0d exp 00000/01/0", k, {busy, clk1, clk2, sync, cycle_done}, slot, cycle_cnt);
                end
                poc = 1'b0;
            end
        end
        exp_cnt = 4'd0;
    endtask

    // run and step_req on the same edge, 16 continuous cycles: 4-bit counter wraps to 0
    task automatic test_wrap_both();
        logic       e_c1, e_dn, e_bz;
        logic [7:0] e_sl;
        logic [3:0] e_cn;
        div = 8'd0; run = 1'b1; step_req = 1'b1;
        @(posedge clk);
        for (int k = 0; k <= 513; k++) begin
            @(negedge clk);
            e_bz = (k < 512);
            e_c1 = e_bz && (k % 4 == 0);
            e_dn = e_bz && (k % 32 == 31);
            e_sl = e_bz ? (8'd1 << ((k / 4) % 8)) : 8'd1;
            e_cn = 4'(((k < 512) ? k + 1 : 512) / 32);
            checks++;
            if ({busy, clk1, cycle_done} !== {e_bz, e_c1, e_dn}) begin
                errors++; $display("FAIL wrap_flags k=%0d got %b exp %b", k, {busy, clk1, cycle_done}, {e_bz, e_c1, e_dn});
            end
            checks++;
            if (slot !== e_sl) begin
                errors++; $display("FAIL wrap_slot k=%0d got %h exp %h", k, slot, e_sl);
            end
            checks++;
            if (cycle_cnt !== e_cn) begin
                errors++; $display("FAIL wrap_cnt k=%0d got %0d exp %0d", k, cycle_cnt, e_cn);
            end
            step_req = 1'b0;
            run = (k < 500);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        exp_cnt = 4'd0;
        poc = 1'b1; run = 1'b0; step_req = 1'b0; div = 8'd0;
        test_reset();
        test_step();
        test_run_div2();
        test_drain();
        test_div_change();
        test_poc();
        test_wrap_both();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
